// File: rtl/array_job_arbiter.sv
// array_job_arbiter: round-robin arbiter feeding one job at a time (load, compute wait, drain) to a systolic array.
module array_job_arbiter #(
  parameter int COMPUTE_LAT = 3,
  parameter int BEATS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       tr0,
  input  logic       tr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       load_en,
  output logic [7:0] arr_data,
  output logic       transpose,
  input  logic [7:0] arr_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;
  localparam logic [3:0] BEAT_LAST = 4'(BEATS - 1);
  localparam logic [3:0] WAIT_LAST = 4'(COMPUTE_LAT - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q;
  logic prio_q, gnt0_q, gnt1_q, tr_q, rsp_valid_q, rsp_id_q;
  logic [7:0] rsp_data_q;
  logic win1, last;
  always_comb begin
    win1 = req1 & (~req0 | prio_q);
    last = (state_q == WAIT) ? (cnt_q == WAIT_LAST) : (cnt_q == BEAT_LAST);
  end
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req0 | req1) ? LOAD : IDLE;
      LOAD:    state_d = last ? WAIT : LOAD;
      WAIT:    state_d = last ? DRAIN : WAIT;
      default: state_d = last ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      tr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      cnt_q       <= (state_d != state_q || state_q == IDLE) ? 4'd0 : cnt_q + 4'd1;
      rsp_valid_q <= state_q == DRAIN;
      if (state_q == IDLE && state_d == LOAD) begin
        gnt0_q <= ~win1;
        gnt1_q <= win1;
        tr_q   <= win1 ? tr1 : tr0;
      end
      if (state_q == DRAIN) begin
        rsp_data_q <= arr_out;
        rsp_id_q   <= gnt1_q;
      end
      // pointer moves to the requester that lost this job once it fully drains
      if (state_q == DRAIN && last) begin
        gnt0_q <= 1'b0;
        gnt1_q <= 1'b0;
        prio_q <= gnt0_q;
      end
    end
  always_comb begin
    gnt0      = gnt0_q;
    gnt1      = gnt1_q;
    load_en   = state_q == LOAD;
    arr_data  = gnt0_q ? data0 : gnt1_q ? data1 : 8'h00;
    transpose = tr_q;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    busy      = state_q != IDLE;
  end
endmodule

// File: tb/tb_array_job_arbiter.sv
// tb_array_job_arbiter: directed scenarios for grant order, load/drain timing, transpose capture and reset.
module tb_array_job_arbiter;
  localparam int BEATS = 8;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, tr0 = 1'b0, tr1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0, arr_out = '0;
  logic gnt0, gnt1, load_en, transpose, rsp_valid, rsp_id, busy;
  logic [7:0] arr_data, rsp_data;
  int total = 0, bad = 0;
  array_job_arbiter #(.COMPUTE_LAT(LAT), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .tr0(tr0), .tr1(tr1), .gnt0(gnt0), .gnt1(gnt1), .load_en(load_en),
    .arr_data(arr_data), .transpose(transpose), .arr_out(arr_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string name);
    total++;
    if ({gnt1, gnt0, load_en, rsp_valid, rsp_id, transpose, busy} !== 7'b0 || rsp_data !== 8'h00 || arr_data !== 8'h00) begin
      bad++;
      $display("FAIL %s: gnt=%b load_en=%b rsp_valid=%b rsp_id=%b tr=%b busy=%b rsp_data=%h arr_data=%h, all required 0",
               name, {gnt1, gnt0}, load_en, rsp_valid, rsp_id, transpose, busy, rsp_data, arr_data);
    end
  endtask
  // caller sets requests in an IDLE cycle; returns in the first IDLE cycle after the job
  task automatic run_job(input bit id, input bit tr_exp, input int raise_beat);
    logic [7:0] exp_d;
    logic [1:0] exp_g;
    exp_g = id ? 2'b10 : 2'b01;
    step();
    for (int i = 0; i < BEATS; i++) begin
      data0 = 8'h01 + 8'(i);
      data1 = 8'hA1 + 8'(i);
      tr0 = i[0];
      tr1 = ~i[0];
      if (i == raise_beat) begin
        if (id) req0 = 1'b1;
        else req1 = 1'b1;
      end
      #1;
      exp_d = (id ? 8'hA1 : 8'h01) + 8'(i);
      total++;
      if ({gnt1, gnt0} !== exp_g) begin
        bad++;
        $display("FAIL load_gnt id%0d beat %0d: got %b want %b", id, i, {gnt1, gnt0}, exp_g);
      end
      total++;
      if (load_en !== 1'b1 || arr_data !== exp_d) begin
        bad++;
        $display("FAIL load_data id%0d beat %0d: load_en=%b arr_data=%h want 1 %h", id, i, load_en, arr_data, exp_d);
      end
      total++;
      if (transpose !== tr_exp || busy !== 1'b1 || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL load_misc id%0d beat %0d: tr=%b busy=%b rsp_valid=%b want %b 1 0", id, i, transpose, busy, rsp_valid, tr_exp);
      end
      step();
    end
    for (int i = 0; i < LAT; i++) begin
      if (i == 0) begin
        if (id) req1 = 1'b0;
        else req0 = 1'b0;
      end
      total++;
      if (load_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1 || {gnt1, gnt0} !== exp_g || transpose !== tr_exp) begin
        bad++;
        $display("FAIL wait id%0d cyc %0d: load_en=%b rsp_valid=%b busy=%b gnt=%b tr=%b want 0 0 1 %b %b",
                 id, i, load_en, rsp_valid, busy, {gnt1, gnt0}, transpose, exp_g, tr_exp);
      end
      step();
    end
    for (int i = 0; i < BEATS; i++) begin
      arr_out = 8'h80 + 8'(i * 3);
      total++;
      if (rsp_valid !== (i > 0) || {gnt1, gnt0} !== exp_g || busy !== 1'b1 || load_en !== 1'b0) begin
        bad++;
        $display("FAIL drain_ctl id%0d beat %0d: rsp_valid=%b gnt=%b busy=%b load_en=%b want %b %b 1 0",
                 id, i, rsp_valid, {gnt1, gnt0}, busy, load_en, i > 0, exp_g);
      end
      if (i > 0) begin
        total++;
        if (rsp_data !== 8'h80 + 8'((i - 1) * 3) || rsp_id !== id) begin
          bad++;
          $display("FAIL drain_data id%0d beat %0d: rsp_data=%h rsp_id=%b want %h %b",
                   id, i, rsp_data, rsp_id, 8'h80 + 8'((i - 1) * 3), id);
        end
      end
      step();
    end
    total++;
    if (busy !== 1'b0 || {gnt1, gnt0} !== 2'b00 || rsp_valid !== 1'b1 || rsp_data !== 8'h80 + 8'((BEATS - 1) * 3) || rsp_id !== id) begin
      bad++;
      $display("FAIL job_end id%0d: busy=%b gnt=%b rsp_valid=%b rsp_data=%h rsp_id=%b want 0 00 1 %h %b",
               id, busy, {gnt1, gnt0}, rsp_valid, rsp_data, rsp_id, 8'h80 + 8'((BEATS - 1) * 3), id);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    data0 = 8'h55;
    data1 = 8'h66;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();
    check_zero("idle_no_req");
  endtask
  task automatic test_single();
    req0 = 1'b1;
    tr0 = 1'b0;
    run_job(1'b0, 1'b0, -1);
  endtask
  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    tr0 = 1'b1;
    tr1 = 1'b0;
    run_job(1'b0, 1'b1, -1);
    req0 = 1'b1;
    tr0 = 1'b1;
    tr1 = 1'b0;
    run_job(1'b1, 1'b0, -1);
    req1 = 1'b1;
    tr0 = 1'b0;
    tr1 = 1'b1;
    run_job(1'b0, 1'b0, -1);
    req1 = 1'b0;
  endtask
  task automatic test_mid_load_request();
    req0 = 1'b1;
    tr0 = 1'b1;
    run_job(1'b0, 1'b1, 2);
    tr1 = 1'b1;
    run_job(1'b1, 1'b1, -1);
  endtask
  task automatic test_reset_in_drain();
    req0 = 1'b1;
    step();
    repeat (BEATS - 1 + 1 + LAT + 3) step();
    total++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_drain: busy=%b rsp_valid=%b gnt0=%b want 1 1 1", busy, rsp_valid, gnt0);
    end
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b1;
    tr1 = 1'b1;
    step();
    check_zero("reset_in_drain");
    rst = 1'b0;
    step();
    total++;
    if ({gnt1, gnt0} !== 2'b10 || load_en !== 1'b1 || transpose !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL grant_after_reset: gnt=%b load_en=%b tr=%b rsp_valid=%b want 10 1 1 0", {gnt1, gnt0}, load_en, transpose, rsp_valid);
    end
    req1 = 1'b0;
    repeat (BEATS - 1 + LAT + BEATS + 2) step();
    total++;
    if (busy !== 1'b0 || rsp_id !== 1'b1 || {gnt1, gnt0} !== 2'b00) begin
      bad++;
      $display("FAIL after_reset_job: busy=%b rsp_id=%b gnt=%b want 0 1 00", busy, rsp_id, {gnt1, gnt0});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_load_request();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
